// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared types and sizing helpers for the nibble-serial subtractor.
package nibble_serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int SLICE_W = 4;

  function automatic int nslice(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/nibble_serial_subtractor_bla_slice4.sv
// Combinational 4-bit borrow-lookahead subtractor: d = a - b - bin.
module bla_slice4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout
);

  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [4:0] w_br;

  // Propagate when bits are equal, generate when minuend bit is 0 and subtrahend 1.
  assign w_p = ~(a ^ b);
  assign w_g = ~a & b;

  assign w_br[0] = bin;
  assign w_br[1] = w_g[0] | (w_p[0] & bin);
  assign w_br[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & bin);
  assign w_br[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & bin);
  assign w_br[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                 | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & bin);

  assign d    = a ^ b ^ w_br[3:0];
  assign bout = w_br[4];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor: one 4-bit borrow-lookahead slice per clock, LSB first,
// with a start/busy/done handshake. diff = a - b - bin, bout = unsigned borrow.
module nibble_serial_subtractor
  import nibble_serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int NSLICE = nslice(WIDTH);
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_width_check
    $error("nibble_serial_subtractor: WIDTH must be a positive multiple of 4");
  end

  state_e             r_state;
  state_e             w_state_nx;
  logic [IDX_W-1:0]   r_idx;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_borrow;
  logic [WIDTH-1:0]   r_diff;
  logic               r_bout;

  logic               w_accept;
  logic               w_last;
  logic [SLICE_W-1:0] w_a_sl;
  logic [SLICE_W-1:0] w_b_sl;
  logic [SLICE_W-1:0] w_d;
  logic               w_bo;

  // DONE behaves like IDLE for acceptance so back-to-back ops have no bubble.
  assign w_accept = start && (r_state != RUN);
  assign w_last   = (r_idx == LAST_IDX);

  assign w_a_sl = r_a[int'(r_idx) * SLICE_W +: SLICE_W];
  assign w_b_sl = r_b[int'(r_idx) * SLICE_W +: SLICE_W];

  bla_slice4 u_slice (
    .a    (w_a_sl),
    .b    (w_b_sl),
    .bin  (r_borrow),
    .d    (w_d),
    .bout (w_bo)
  );

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_nx = RUN;
      RUN:     if (w_last) w_state_nx = DONE;
      DONE:    w_state_nx = start ? RUN : IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_borrow <= 1'b0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (w_accept) begin
        r_a      <= a;
        r_b      <= b;
        r_borrow <= bin;
        r_idx    <= '0;
        r_diff   <= '0;
      end else if (r_state == RUN) begin
        r_diff[int'(r_idx) * SLICE_W +: SLICE_W] <= w_d;
        r_borrow <= w_bo;
        if (w_last) begin
          r_bout <= w_bo;
          r_idx  <= '0;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign diff = r_diff;
  assign bout = r_bout;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed + random checks of the nibble-serial subtractor (WIDTH=16 and WIDTH=4).
module tb_nibble_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a, b;
  logic        bin;
  logic        busy, done, bout;
  logic [15:0] diff;

  logic        start4;
  logic [3:0]  a4, b4;
  logic        bin4;
  logic        busy4, done4, bout4;
  logic [3:0]  diff4;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nibble_serial_subtractor #(.WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
  );

  nibble_serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
  );

  // Reference: plain unsigned subtraction one bit wider; the top bit is the borrow.
  function automatic logic [16:0] ref16(input logic [15:0] x, input logic [15:0] y,
                                        input logic bi);
    return {1'b0, x} - {1'b0, y} - 17'(bi);
  endfunction

  function automatic logic [4:0] ref4(input logic [3:0] x, input logic [3:0] y,
                                      input logic bi);
    return {1'b0, x} - {1'b0, y} - 5'(bi);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full operation from IDLE: start in cycle 0, partials in cycles 2..5, done in cycle 5.
  task automatic op16(input string tag, input logic [15:0] x, input logic [15:0] y,
                      input logic bi);
    logic [16:0] r;
    r = ref16(x, y, bi);
    a = x; b = y; bin = bi; start = 1'b1;
    tick();
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
    chk({tag, ".busy1"}, 32'(busy), 32'd1);
    chk({tag, ".done1"}, 32'(done), 32'd0);
    chk({tag, ".clr"},   32'(diff), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("%s.nib%0d", tag, k), 32'((diff >> (4 * k)) & 16'hF),
          32'((r[15:0] >> (4 * k)) & 16'hF));
      if (k < 3) begin
        chk($sformatf("%s.busy%0d", tag, k + 2), 32'(busy), 32'd1);
        chk($sformatf("%s.done%0d", tag, k + 2), 32'(done), 32'd0);
      end
    end
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".busy5"}, 32'(busy), 32'd0);
    chk({tag, ".diff"}, 32'(diff), 32'(r[15:0]));
    chk({tag, ".bout"}, 32'(bout), 32'(r[16]));
    tick();
    chk({tag, ".done6"}, 32'(done), 32'd0);
    chk({tag, ".hold"}, 32'(diff), 32'(r[15:0]));
  endtask

  initial begin
    logic [16:0] r1, r2;
    logic [4:0]  r4;
    logic [15:0] xa, xb;
    logic        xbi;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.diff", 32'(diff), 32'd0);
    chk("rst.bout", 32'(bout), 32'd0);
    chk("rst.busy4", 32'(busy4), 32'd0);

    op16("basic", 16'h1234, 16'h0034, 1'b0);
    op16("under", 16'h0000, 16'h0001, 1'b0);
    op16("eqbin", 16'hA5A5, 16'hA5A5, 1'b1);
    op16("chain", 16'h1000, 16'h0001, 1'b0);
    op16("max",   16'hFFFF, 16'h0000, 1'b1);

    // Mid-run start ignored; start in DONE cycle accepted back-to-back.
    r1 = ref16(16'h8421, 16'h1248, 1'b0);
    r2 = ref16(16'h0F0F, 16'hF0F0, 1'b1);
    a = 16'h8421; b = 16'h1248; bin = 1'b0; start = 1'b1;
    tick();                                   // cycle 1
    start = 1'b0;
    tick();                                   // cycle 2
    a = 16'hFFFF; b = 16'h0001; bin = 1'b1; start = 1'b1;
    tick();                                   // cycle 3
    start = 1'b0;
    chk("b2b.busy3", 32'(busy), 32'd1);
    tick(); tick();                           // cycle 5
    chk("b2b.done1", 32'(done), 32'd1);
    chk("b2b.diff1", 32'(diff), 32'(r1[15:0]));
    chk("b2b.bout1", 32'(bout), 32'(r1[16]));
    a = 16'h0F0F; b = 16'hF0F0; bin = 1'b1; start = 1'b1;
    tick();                                   // cycle 6
    start = 1'b0;
    chk("b2b.busy6", 32'(busy), 32'd1);
    chk("b2b.done6", 32'(done), 32'd0);
    tick(); tick(); tick();                   // cycle 9
    chk("b2b.done9", 32'(done), 32'd0);
    tick();                                   // cycle 10
    chk("b2b.done2", 32'(done), 32'd1);
    chk("b2b.diff2", 32'(diff), 32'(r2[15:0]));
    chk("b2b.bout2", 32'(bout), 32'(r2[16]));
    tick();

    // Reset mid-run abandons the operation.
    a = 16'h0000; b = 16'hFFFF; bin = 1'b1; start = 1'b1;
    tick();                                   // cycle 1
    start = 1'b0;
    tick();                                   // cycle 2
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst.busy", 32'(busy), 32'd0);
    chk("mrst.done", 32'(done), 32'd0);
    chk("mrst.diff", 32'(diff), 32'd0);
    chk("mrst.bout", 32'(bout), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("mrst.nodone%0d", i), 32'(done), 32'd0);
    end
    op16("postrst", 16'h4000, 16'h3FFF, 1'b1);

    for (int i = 0; i < 20; i++) begin
      xa = 16'($urandom); xb = 16'($urandom); xbi = 1'($urandom);
      if (i % 4 == 0) xb = xa;
      op16($sformatf("rnd%0d", i), xa, xb, xbi);
    end

    // WIDTH=4 build: single slice, done two cycles after start.
    for (int i = 0; i < 9; i++) begin
      if (i == 0) begin
        a4 = 4'h3; b4 = 4'h5; bin4 = 1'b0;
      end else begin
        a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
      end
      r4 = ref4(a4, b4, bin4);
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      a4 = 4'($urandom); b4 = 4'($urandom);
      chk($sformatf("w4_%0d.busy", i), 32'(busy4), 32'd1);
      chk($sformatf("w4_%0d.done1", i), 32'(done4), 32'd0);
      tick();
      chk($sformatf("w4_%0d.done", i), 32'(done4), 32'd1);
      chk($sformatf("w4_%0d.diff", i), 32'(diff4), 32'(r4[3:0]));
      chk($sformatf("w4_%0d.bout", i), 32'(bout4), 32'(r4[4]));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
